des_key_schedule: RTL and testbench

- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one per round, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits upstream of the S-box substitution stage. Its subkey output is XORed with the 48-bit expanded right half, and the result drives the 48-bit S-box input.
- Uses a valid/ready handshake so the round datapath can consume subkeys at its own rate.

---
 rtl/des_key_schedule.sv | 203 ++++++++++++++++++++
 tb/tb_des_key_schedule.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
`default_nettype none
// ==========================================================================
// des_key_schedule : DES round-subkey generator (K1..K16 or K16..K1), valid/ready
// Optional: DES_KEY_PARITY_CHECK_EN adds per-byte odd-parity rejection of key_in
// Revision: 1.0
// ==========================================================================
module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        load,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        key_parity_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Table entries use DES bit numbering (1 = MSB).
  localparam int C_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int C_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [3:0] C_LAST_ROUND = 4'(ROUNDS - 1);

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-C_PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-C_PC2[i]];
    return r;
  endfunction

  function automatic logic [55:0] f_rotl(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  function automatic logic [55:0] f_rotr(input logic [55:0] cd, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

  // Rounds 1, 2, 9 and 16 (1-based) shift by one; every other round by two.
  function automatic logic f_shift_one(input logic [4:0] rnum);
    return (rnum == 5'd1) || (rnum == 5'd2) || (rnum == 5'd9) || (rnum == 5'd16);
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [55:0] r_cd;
  logic [47:0] r_subkey;
  logic [3:0]  r_round;
  logic        r_decrypt;

  logic        w_parity_ok;
  logic        w_load_ok;
  logic        w_accept;
  logic        w_last;
  logic [55:0] w_pc1;
  logic [55:0] w_cd_load;
  logic [55:0] w_cd_next;
  logic [4:0]  w_enc_rnum;
  logic [4:0]  w_dec_rnum;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] w_byte_odd;
  logic       r_parity_err;

  for (genvar b = 0; b < 8; b++) begin : g_parity
    assign w_byte_odd[b] = ^key_in[8*b +: 8];
  end

  assign w_parity_ok = &w_byte_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (r_state == S_IDLE) && load && !w_parity_ok;
    end
  end

  assign key_parity_err = r_parity_err;
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_load_ok  = (r_state == S_IDLE) && load && w_parity_ok;
  assign w_accept   = (r_state == S_RUN) && subkey_ready;
  assign w_last     = (r_round == C_LAST_ROUND);
  assign w_pc1      = f_pc1(key_in);
  // Decrypt starts at K16, whose cumulative shift of 28 is the identity.
  assign w_cd_load  = decrypt ? w_pc1 : f_rotl(w_pc1, 1'b0);
  assign w_enc_rnum = 5'(r_round) + 5'd2;
  assign w_dec_rnum = 5'd16 - 5'(r_round);
  assign w_cd_next  = r_decrypt ? f_rotr(r_cd, !f_shift_one(w_dec_rnum))
                                : f_rotl(r_cd, !f_shift_one(w_enc_rnum));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cd      <= '0;
      r_subkey  <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
    end else if (w_load_ok) begin
      r_cd      <= w_cd_load;
      r_subkey  <= f_pc2(w_cd_load);
      r_round   <= '0;
      r_decrypt <= decrypt;
    end else if (w_accept) begin
      if (!w_last) begin
        r_cd     <= w_cd_next;
        r_subkey <= f_pc2(w_cd_next);
        r_round  <= r_round + 4'd1;
      end else begin
        r_round  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    subkey_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load_ok) w_state_next = S_RUN;
      end
      S_RUN: begin
        subkey_valid = 1'b1;
        busy         = 1'b1;
        if (w_accept && w_last) w_state_next = S_FIN;
      end
      S_FIN: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign subkey = r_subkey;
  assign round  = r_round;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        load;
  logic        decrypt;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        key_parity_err;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KEXP [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule #(.ROUNDS(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .load          (load),
    .decrypt       (decrypt),
    .subkey_ready  (subkey_ready),
    .subkey        (subkey),
    .subkey_valid  (subkey_valid),
    .round         (round),
    .busy          (busy),
    .done          (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .key_parity_err(key_parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full schedule with ready high, optional 5-cycle stall and a stray load.
  task automatic run_sched(input bit dec, input int stall_at, input int load_at);
    logic [47:0] exp;
    exp = '0;
    key_in = KEY;
    decrypt = dec;
    load = 1'b1;
    subkey_ready = 1'b1;
    tick;
    load = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = ~dec;
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("parity_err_ok", 64'(key_parity_err), 64'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      exp = dec ? KEXP[15-i] : KEXP[i];
      chk("valid", 64'(subkey_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("round", 64'(round), 64'(i));
      chk("subkey", 64'(subkey), 64'(exp));
      if (i == stall_at) begin
        subkey_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick;
          chk("stall_subkey", 64'(subkey), 64'(exp));
          chk("stall_round", 64'(round), 64'(i));
          chk("stall_busy", 64'(busy), 64'd1);
          chk("stall_valid", 64'(subkey_valid), 64'd1);
        end
        subkey_ready = 1'b1;
      end
      if (i == load_at) begin
        load = 1'b1;
        key_in = 64'd0;
        decrypt = ~dec;
      end
      tick;
      load = 1'b0;
    end
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_valid", 64'(subkey_valid), 64'd0);
    chk("fin_round", 64'(round), 64'd0);
    chk("fin_subkey_hold", 64'(subkey), 64'(exp));
    tick;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_in = '0;
    load = 1'b0;
    decrypt = 1'b0;
    subkey_ready = 1'b0;
    tick;
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    subkey_ready = 1'b1;
    tick;
    chk("idle_ready_no_effect", 64'(subkey_valid), 64'd0);

    // Encrypt, then decrypt loaded in the IDLE cycle right after FIN.
    run_sched(1'b0, -1, -1);
    run_sched(1'b1, -1, -1);
    // Backpressure at round 3, stray load at round 7.
    run_sched(1'b0, 3, -1);
    run_sched(1'b0, -1, 7);
    run_sched(1'b1, 3, 7);

    // Reset in the middle of a schedule.
    key_in = KEY;
    decrypt = 1'b0;
    load = 1'b1;
    subkey_ready = 1'b1;
    tick;
    load = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("pre_rst_round", 64'(round), 64'd5);
    chk("pre_rst_subkey", 64'(subkey), 64'(KEXP[5]));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_subkey", 64'(subkey), 64'd0);
    chk("async_rst_valid", 64'(subkey_valid), 64'd0);
    chk("async_rst_round", 64'(round), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("post_rst_valid", 64'(subkey_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_sched(1'b0, -1, -1);

`ifdef DES_KEY_PARITY_CHECK_EN
    key_in = 64'h133457799BBCDFF0;
    decrypt = 1'b0;
    load = 1'b1;
    tick;
    load = 1'b0;
    chk("parity_err_set", 64'(key_parity_err), 64'd1);
    chk("parity_busy", 64'(busy), 64'd0);
    chk("parity_valid", 64'(subkey_valid), 64'd0);
    tick;
    chk("parity_err_pulse", 64'(key_parity_err), 64'd0);
    chk("parity_still_idle", 64'(busy), 64'd0);
    run_sched(1'b0, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
